// File: rtl/demux_pkg.sv
// Shared constants for the buffered 1:2 demultiplexer: channel IDs and default sizing.
package demux_pkg;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  localparam int unsigned W_DEF     = 4;
  localparam int unsigned DEPTH_DEF = 2;

endpackage

// File: rtl/demux_fifo.sv
// Per-channel synchronous FIFO; head reads zero when empty, no write-to-read bypass.
module demux_fifo #(
  parameter  int unsigned W     = 4,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] count_nxt;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Occupancy: EMPTY / PARTIAL / FULL, +1 on push-only, -1 on pop-only, else hold
  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count <= count_nxt;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Storage needs no reset; empty masks stale contents
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/demux12_4_buf.sv
// Buffered 1:2 demultiplexer: steers a tagged input stream into two independent channel FIFOs.
module demux12_4_buf
  import demux_pkg::*;
#(
  parameter  int unsigned W     = W_DEF,
  parameter  int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  input  logic          i_s,
  input  logic [W-1:0]  i_w,
  output logic          o_ready,
  output logic          o_valid0,
  output logic [W-1:0]  o_w0,
  input  logic          i_ready0,
  output logic          o_valid1,
  output logic [W-1:0]  o_w1,
  input  logic          i_ready1,
  output logic [CW-1:0] o_count0,
  output logic [CW-1:0] o_count1
);

  logic full0;
  logic full1;
  logic empty0;
  logic empty1;
  logic push0;
  logic push1;

  // Ready depends only on the selected channel's fullness, never on the consumer side
  assign o_ready = (i_s == CH1) ? !full1 : !full0;
  assign push0   = i_valid && o_ready && (i_s == CH0);
  assign push1   = i_valid && o_ready && (i_s == CH1);

  assign o_valid0 = !empty0;
  assign o_valid1 = !empty1;

  demux_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push0),
    .din   (i_w),
    .pop   (i_ready0),
    .full  (full0),
    .empty (empty0),
    .count (o_count0),
    .head  (o_w0)
  );

  demux_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push1),
    .din   (i_w),
    .pop   (i_ready1),
    .full  (full1),
    .empty (empty1),
    .count (o_count1),
    .head  (o_w1)
  );

endmodule
